regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
//  Parametrised multi-port register file for the dual-issue pipeline.
//  - NRD combinational read ports and NWR synchronous write ports.
//  - Hard-wired zero register.
//  - Deterministic post-reset clear sequence.
//  - Optional same-cycle write-to-read bypass.
//  Sits in the decode stage: writes from WB lanes, reads to ID/EX operand muxes.
// PARAMETERS
//  XLEN     32  data width in bits
//  NREGS    32  number of architectural registers (power of 2, >=2)
//  NRD       4  number of read ports
//  NWR       2  number of write ports
//  ZERO_REG  1  1: register 0 reads 0 and ignores writes; 0: register 0 is ordinary
// PORTS
//  clk         in   1                  clock, rising edge
//  rst         in   1                  synchronous, active-high reset
//  ready       out  1                  1 = clear done, file usable
//  read_reg    in   NRD x $clog2(NREGS) read addresses
//  read_data   out  NRD x XLEN          read data (combinational)
//  write_en    in   NWR                 per-port write enable
//  write_reg   in   NWR x $clog2(NREGS) write addresses
//  write_data  in   NWR x XLEN          write data
// BEHAVIOUR
//  - State machine: CLEAR -> RUN.
//    - rst=1 (any state, any cycle): next state CLEAR, clear counter cnt <= 0. No register written.
//    - CLEAR, rst=0: registers[cnt] <= 0, then cnt++. When cnt==NREGS-1 the next state is RUN.
//    - ready rises exactly NREGS clocks after the first clock with rst=0.
//    - rst asserted mid-clear restarts the clear at cnt=0.
//  - Reset values: ready=0. While in CLEAR, every read_data port = 0 and all write_en are ignored.
//  - RUN: on posedge, for each port p with write_en[p]=1, registers[write_reg[p]] <= write_data[p].
//    - If ZERO_REG=1 and write_reg[p]==0, the write is dropped.
//  - Write conflict (two ports, same address, same cycle): the highest-numbered port wins.
//    No error is flagged.
//  - Reads are combinational with zero latency.
//    - If ZERO_REG=1 and read_reg==0, read_data=0 regardless of bypass.
//    - Otherwise read_data = registers[read_reg], subject to bypass (see CONFIGURATION).
//  - Any number of read ports may read the same address simultaneously.
//  - All arithmetic on cnt uses $clog2(NREGS) bits. cnt never wraps, because CLEAR exits at NREGS-1.
// CONFIGURATION
//  Macro REGFILE_BYPASS_EN
//  - Defined: in RUN, a read whose address matches an enabled, non-dropped write in the same
//    cycle returns that write's data. On a multi-port match, the highest-numbered port's data
//    is returned, consistent with write priority.
//  - Undefined: reads return the stored value; newly written data is visible from the next cycle.
//  - In CLEAR, reads return 0 either way.
// STRUCTURE
//  - types_pkg: reuse word_t and reg_addr_t. Add typedef enum logic {RF_CLEAR, RF_RUN} rf_state_e.
//  - No new constants beyond the parameters.
//  - One sub-module, rf_clear_seq: owns state, cnt and ready, and outputs clr_we and clr_addr.
//  - The top level holds the storage array, the write-priority loop and the per-port read/bypass mux.
// TESTING
//  1. Reset: rst=1 for 3 clks, then 0. ready=0 for exactly 32 clks, then 1;
//     all 32 registers read 0.
//  2. Basic: in RUN, port0 writes x5=0xDEADBEEF and port1 writes x6=0x12345678.
//     Next cycle: read_reg={5,6,0,5} -> read_data={DEADBEEF,12345678,0,DEADBEEF}.
//  3. Conflict: both ports write x7, port0=0x1111 and port1=0x2222 -> x7 reads 0x2222 next cycle.
//  4. Zero reg: write x0=0xFFFFFFFF on both ports -> x0 reads 0 (ZERO_REG=1).
//     With ZERO_REG=0, the same write reads back 0xFFFFFFFF.
//  5. Bypass: x9 holds 0xA; same cycle port1 writes x9=0xB with read_reg[0]=9.
//     -> 0xB with REGFILE_BYPASS_EN defined, 0xA without it.
//  6. Reset mid-clear: deassert rst, reassert at clk 10, release again.
//     -> ready rises 32 clks after the second release. A write attempted during CLEAR is never visible.

Source files
------------

// File: rtl/types_pkg.sv
// Shared types for the decode-stage register file.
// word_t / reg_addr_t: default-width architectural word and register index.
// rf_state_e: clear-sequencer state (CLEAR after reset, RUN once every register is zeroed).
package types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  reg_addr_t;

  typedef enum logic {RF_CLEAR, RF_RUN} rf_state_e;

endpackage

// File: rtl/regfile_mp_clear_seq.sv
// rf_clear_seq: post-reset clear sequencer for regfile_mp.
// Ports: clk/rst (sync, active-high) in; ready out (1 once clear is complete);
//        clr_we/clr_addr out (one register zeroed per clock while clearing).
module rf_clear_seq
  import types_pkg::*;
#(
  parameter  int NREGS = 32,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  output logic          ready,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  rf_state_e     state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RF_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    clr_we   = 1'b0;
    clr_addr = cnt_q;
    // rst wins over clearing: a reset cycle writes nothing and restarts at cnt=0.
    if (!rst && state_q == RF_CLEAR) begin
      clr_we = 1'b1;
      // Counter holds at the last index instead of wrapping; state change ends clearing.
      if (cnt_q == AW'(NREGS - 1)) begin
        state_d = RF_RUN;
      end else begin
        cnt_d = cnt_q + AW'(1);
      end
    end
  end

  assign ready = (state_q == RF_RUN);

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file (NRD comb read ports, NWR sync write ports).
// Ports: clk, rst (sync, active-high), ready, read_reg/read_data, write_en/write_reg/write_data.
// Optional macro REGFILE_BYPASS_EN: same-cycle write data forwarded to matching reads in RUN.
module regfile_mp
  import types_pkg::*;
#(
  parameter  int XLEN     = 32,
  parameter  int NREGS    = 32,
  parameter  int NRD      = 4,
  parameter  int NWR      = 2,
  parameter  int ZERO_REG = 1,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      ready,
  input  logic [NRD-1:0][AW-1:0]    read_reg,
  output logic [NRD-1:0][XLEN-1:0]  read_data,
  input  logic [NWR-1:0]            write_en,
  input  logic [NWR-1:0][AW-1:0]    write_reg,
  input  logic [NWR-1:0][XLEN-1:0]  write_data
);

  logic          clr_we;
  logic [AW-1:0] clr_addr;

  rf_clear_seq #(.NREGS(NREGS)) u_clear_seq (
    .clk      (clk),
    .rst      (rst),
    .ready    (ready),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];

  // Contents need no reset: the clear sequence zeroes every entry before ready.
  always_ff @(posedge clk) begin
    regs_q <= regs_d;
  end

  always_comb begin
    regs_d = regs_q;
    if (clr_we) begin
      regs_d[clr_addr] = '0;
    end else if (ready && !rst) begin
      // Ascending loop: later (higher-numbered) ports overwrite earlier ones on a conflict.
      for (int p = 0; p < NWR; p++) begin
        if (write_en[p] && !(ZERO_REG != 0 && write_reg[p] == '0)) begin
          regs_d[write_reg[p]] = write_data[p];
        end
      end
    end
  end

  always_comb begin
    for (int r = 0; r < NRD; r++) begin
      read_data[r] = '0;
      if (ready && !(ZERO_REG != 0 && read_reg[r] == '0)) begin
        read_data[r] = regs_q[read_reg[r]];
`ifdef REGFILE_BYPASS_EN
        // Only writes that will actually land are forwarded; a reset cycle drops them all.
        // Address 0 with ZERO_REG never reaches here, so dropped writes need no extra check.
        if (!rst) begin
          for (int w = 0; w < NWR; w++) begin
            if (write_en[w] && write_reg[w] == read_reg[r]) begin
              read_data[r] = write_data[w];
            end
          end
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;
  import types_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 ready_z, ready_nz;
  reg_addr_t [3:0]      rr;
  word_t     [3:0]      rd_z, rd_nz;
  logic      [1:0]      we;
  reg_addr_t [1:0]      wr;
  word_t     [1:0]      wd;

  always #5 clk = ~clk;

  regfile_mp #(.ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .ready(ready_z), .read_reg(rr), .read_data(rd_z),
    .write_en(we), .write_reg(wr), .write_data(wd)
  );

  regfile_mp #(.ZERO_REG(0)) dut_nz (
    .clk(clk), .rst(rst), .ready(ready_nz), .read_reg(rr), .read_data(rd_nz),
    .write_en(we), .write_reg(wr), .write_data(wd)
  );

  int vecs = 0;
  int errs = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // since: clocks since the last rst=1 clock; the file is usable once 32 have elapsed.
  int    since = 0;
  word_t mem_z  [32];
  word_t mem_nz [32];

  always @(posedge clk) begin
    if (rst) begin
      since = 0;
    end else if (since >= 32) begin
      for (int p = 0; p < 2; p++) begin
        if (we[p]) begin
          if (wr[p] != 0) mem_z[wr[p]] = wd[p];
          mem_nz[wr[p]] = wd[p];
        end
      end
    end else begin
      since++;
      if (since == 32) begin
        for (int i = 0; i < 32; i++) begin
          mem_z[i]  = '0;
          mem_nz[i] = '0;
        end
      end
    end
  end

  function automatic word_t model_read(input bit zr, input reg_addr_t a);
    word_t v;
    if (since < 32) return '0;
    if (zr && a == 0) return '0;
    v = zr ? mem_z[a] : mem_nz[a];
`ifdef REGFILE_BYPASS_EN
    if (!rst) begin
      if (we[0] && wr[0] == a) v = wd[0];
      if (we[1] && wr[1] == a) v = wd[1];
    end
`endif
    return v;
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    #2;
    if (chk_en) begin
      check("ready_z",  {31'd0, ready_z},  {31'd0, since >= 32});
      check("ready_nz", {31'd0, ready_nz}, {31'd0, since >= 32});
      for (int k = 0; k < 4; k++) begin
        check($sformatf("rd_z[%0d]", k),  rd_z[k],  model_read(1'b1, rr[k]));
        check($sformatf("rd_nz[%0d]", k), rd_nz[k], model_read(1'b0, rr[k]));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_ready(output int n);
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      #3;
      if (ready_z === 1'b1) break;
    end
  endtask

  int n;

  initial begin
    rst = 1'b1; rr = '0; we = '0; wr = '0; wd = '0;

    // 1. Reset for 3 clocks, then count clocks to ready.
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    rst = 1'b0;
    #3 check("reset_ready", {31'd0, ready_z}, 32'd0);
    wait_ready(n);
    check("clear_clocks", n, 32'd32);
    for (int i = 0; i < 32; i += 4) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) rr[k] = reg_addr_t'(i + k);
      #3;
      for (int k = 0; k < 4; k++) check("cleared_reg", rd_nz[k], 32'd0);
    end

    // 2. Basic dual write then four-port read.
    @(negedge clk);
    we = 2'b11; wr[0] = 5; wd[0] = 32'hDEADBEEF; wr[1] = 6; wd[1] = 32'h12345678;
    @(negedge clk);
    we = 2'b00; rr[0] = 5; rr[1] = 6; rr[2] = 0; rr[3] = 5;
    #3;
    check("basic_rd0", rd_z[0], 32'hDEADBEEF);
    check("basic_rd1", rd_z[1], 32'h12345678);
    check("basic_rd2", rd_z[2], 32'h0);
    check("basic_rd3", rd_z[3], 32'hDEADBEEF);

    // 3. Same-address conflict: port 1 wins.
    @(negedge clk);
    we = 2'b11; wr[0] = 7; wd[0] = 32'h1111; wr[1] = 7; wd[1] = 32'h2222;
    @(negedge clk);
    we = 2'b00; rr[0] = 7;
    #3 check("conflict_x7", rd_z[0], 32'h2222);

    // 4. Writes to x0 on both ports.
    @(negedge clk);
    we = 2'b11; wr[0] = 0; wd[0] = 32'hFFFFFFFF; wr[1] = 0; wd[1] = 32'hFFFFFFFF;
    @(negedge clk);
    we = 2'b00; rr[0] = 0;
    #3;
    check("zero_reg_x0", rd_z[0], 32'h0);
    check("plain_reg_x0", rd_nz[0], 32'hFFFFFFFF);

    // 5. Same-cycle write/read of x9.
    @(negedge clk);
    we = 2'b01; wr[0] = 9; wd[0] = 32'hA;
    @(negedge clk);
    we = 2'b10; wr[1] = 9; wd[1] = 32'hB; rr[0] = 9;
`ifdef REGFILE_BYPASS_EN
    #3 check("bypass_x9", rd_z[0], 32'hB);
`else
    #3 check("nobypass_x9", rd_z[0], 32'hA);
`endif
    @(negedge clk);
    we = 2'b00;
    #3 check("x9_after", rd_z[0], 32'hB);

    // Extra traffic: spread writes, overlapping reads left to the compare process.
    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
      we = 2'(i);
      wr[0] = reg_addr_t'(i); wd[0] = 32'h01010101 * i;
      wr[1] = reg_addr_t'(31 - i); wd[1] = ~(32'h01010101 * i);
      rr[0] = reg_addr_t'(i); rr[1] = reg_addr_t'(31 - i);
      rr[2] = reg_addr_t'(i - 1); rr[3] = reg_addr_t'(32 - i);
    end
    @(negedge clk);
    we = 2'b00;

    // 6. Reset, release, reassert at clock 10 with a write pending during clear.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    we = 2'b11; wr[0] = 12; wd[0] = 32'h55; wr[1] = 12; wd[1] = 32'h66; rr[0] = 12;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_ready(n);
    we = 2'b00;
    check("reclear_clocks", n, 32'd32);
    @(negedge clk);
    #3;
    check("clear_write_z", rd_z[0], 32'h0);
    check("clear_write_nz", rd_nz[0], 32'h0);

    @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
